// File: rtl/mext_seq.sv
// RV32M multiply/divide sequencer: shift-add multiplier, restoring divider, single-cycle special cases.
// Define MEXT_FAST_ZERO_EN to retire zero-operand ops straight from IDLE to DONE.
module mext_seq #(
  parameter int XLEN               = 32,
  parameter int MUL_BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic [2:0]      mulop,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            stall_in,
  input  logic            flush,
  output logic [XLEN-1:0] out,
  output logic            done,
  output logic            pause
);

  localparam int B  = MUL_BITS_PER_CYCLE;
  localparam int W2 = 2 * XLEN;
  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [W2-1:0]     acc_q, acc_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   out_q, out_d;

  // Operand decode for the op being offered in IDLE.
  logic            s1, s2, rs1_neg, rs2_neg, is_div, div_zero, ovf, fast_zero, neg_new;
  logic [XLEN-1:0] mag1, mag2;

  assign is_div   = mulop[2];
  assign s1       = ~(mulop[0] & (mulop[1] | mulop[2]));
  assign s2       = s1 & (mulop != 3'd2);
  assign rs1_neg  = s1 & rs1[XLEN-1];
  assign rs2_neg  = s2 & rs2[XLEN-1];
  assign mag1     = rs1_neg ? -rs1 : rs1;
  assign mag2     = rs2_neg ? -rs2 : rs2;
  assign div_zero = is_div & (rs2 == '0);
  assign ovf      = ~mulop[0] & is_div & (rs1 == {1'b1, {(XLEN-1){1'b0}}}) & (rs2 == '1);
  // Remainder sign follows the dividend; everything else is the xor of operand signs.
  assign neg_new  = (mulop[2] & mulop[1]) ? rs1_neg : (rs1_neg ^ rs2_neg);

`ifdef MEXT_FAST_ZERO_EN
  assign fast_zero = is_div ? ((rs1 == '0) & (rs2 != '0)) : ((rs1 == '0) | (rs2 == '0));
`else
  assign fast_zero = 1'b0;
`endif

  // Multiply step: acc = {partial product high, remaining multiplier bits}.
  logic [XLEN+B-1:0] mul_pp, mul_sum;
  logic [W2-1:0]     mul_next;
  assign mul_pp   = {{B{1'b0}}, opnd_q} * {{XLEN{1'b0}}, acc_q[B-1:0]};
  assign mul_sum  = {{B{1'b0}}, acc_q[W2-1:XLEN]} + mul_pp;
  assign mul_next = {mul_sum, acc_q[XLEN-1:B]};

  // Restoring divide step: acc = {partial remainder, dividend shifting into quotient}.
  logic [XLEN:0]   div_trial;
  logic            qbit;
  logic [XLEN-1:0] rem_new;
  logic [W2-1:0]   div_next;
  assign div_trial = acc_q[W2-1:XLEN-1] - {1'b0, opnd_q};
  assign qbit      = ~div_trial[XLEN];
  assign rem_new   = qbit ? div_trial[XLEN-1:0] : acc_q[W2-2:XLEN-1];
  assign div_next  = {rem_new, acc_q[XLEN-2:0], qbit};

  logic [W2-1:0]   prod_fix;
  logic [XLEN-1:0] quo_fix, rem_fix, result;
  logic [CW-1:0]   cnt_last;
  assign prod_fix = neg_q ? -mul_next : mul_next;
  assign quo_fix  = neg_q ? -div_next[XLEN-1:0] : div_next[XLEN-1:0];
  assign rem_fix  = neg_q ? -div_next[W2-1:XLEN] : div_next[W2-1:XLEN];
  assign cnt_last = op_q[2] ? CW'(XLEN - 1) : CW'(XLEN / B - 1);

  always_comb begin
    result = quo_fix;
    case (op_q)
      3'd0:                result = prod_fix[XLEN-1:0];
      3'd1, 3'd2, 3'd3:    result = prod_fix[W2-1:XLEN];
      3'd6, 3'd7:          result = rem_fix;
      default:             result = quo_fix;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    neg_d   = neg_q;
    out_d   = out_q;
    pause   = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (enable && !flush) begin
          pause = 1'b1;
          op_d  = mulop;
          neg_d = neg_new;
          cnt_d = '0;
          if (div_zero) begin
            out_d   = mulop[1] ? rs1 : '1;
            state_d = S_DONE;
          end else if (ovf) begin
            out_d   = mulop[1] ? '0 : rs1;
            state_d = S_DONE;
          end else if (fast_zero) begin
            out_d   = '0;
            state_d = S_DONE;
          end else begin
            acc_d   = {{XLEN{1'b0}}, (is_div ? mag1 : mag2)};
            opnd_d  = is_div ? mag2 : mag1;
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        pause = 1'b1;
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          acc_d = op_q[2] ? div_next : mul_next;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == cnt_last) begin
            out_d   = result;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        done = ~flush;
        if (flush || !stall_in) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (rst) begin
      pause = 1'b0;
      done  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      neg_q   <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      neg_q   <= neg_d;
      out_q   <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_mext_seq.sv
// Directed plus randomized bench for mext_seq against an arithmetic reference model.
module tb_mext_seq;
  localparam int XLEN = 32;
  localparam int MBPC = 1;

  logic            clk = 1'b0;
  logic            rst, enable, stall_in, flush;
  logic [2:0]      mulop;
  logic [XLEN-1:0] rs1, rs2, out;
  logic            done, pause;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_out = 32'h0;

  mext_seq #(.XLEN(XLEN), .MUL_BITS_PER_CYCLE(MBPC)) dut (
    .clk(clk), .rst(rst), .enable(enable), .mulop(mulop), .rs1(rs1), .rs2(rs2),
    .stall_in(stall_in), .flush(flush), .out(out), .done(done), .pause(pause)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  // Reference results straight from the RV32M definitions using 64-bit arithmetic.
  function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    logic        ovf;
    int          q;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'({32'h0, a});
    ub  = longint'({32'h0, b});
    ovf = (a == 32'h80000000) && (b == 32'hFFFFFFFF);
    ref_res = 32'h0;
    case (op)
      3'd0: begin p = 64'(sa * sb); ref_res = p[31:0]; end
      3'd1: begin p = 64'(sa * sb); ref_res = p[63:32]; end
      3'd2: begin p = 64'(sa * ub); ref_res = p[63:32]; end
      3'd3: begin p = 64'(ua * ub); ref_res = p[63:32]; end
      3'd4: begin
        if (b == 0) ref_res = 32'hFFFFFFFF;
        else if (ovf) ref_res = a;
        else begin q = $signed(a) / $signed(b); ref_res = q; end
      end
      3'd5: ref_res = (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 0) ref_res = a;
        else if (ovf) ref_res = 32'h0;
        else begin q = $signed(a) % $signed(b); ref_res = q; end
      end
      default: ref_res = (b == 0) ? a : a % b;
    endcase
  endfunction

  // Cycle (relative to accept) in which done is expected.
  function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2] && b == 0) return 1;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
`ifdef MEXT_FAST_ZERO_EN
    if (!op[2] && (a == 0 || b == 0)) return 1;
    if (op[2] && a == 0) return 1;
`endif
    return op[2] ? XLEN + 1 : XLEN / MBPC + 1;
  endfunction

  // Called just after the edge that starts cycle 1; returns at the negedge of the done cycle.
  task automatic wait_done(input string tag, input int lat, input logic [31:0] exp);
    int c  = 1;
    int pc = 0;
    bit found = 0;
    while (!found && c <= 80) begin
      @(negedge clk);
      if (pause) pc++;
      if (done) found = 1;
      else c++;
    end
    chk32({tag, " done_cycle"}, 32'(c), 32'(lat));
    chk32({tag, " pause_cycles"}, 32'(pc), 32'(lat - 1));
    chk32({tag, " out"}, out, exp);
    last_out = exp;
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
    @(posedge clk); #1;
    enable = 1'b1; mulop = op; rs1 = a; rs2 = b;
    @(negedge clk);
    chkb({tag, " accept_pause"}, pause, 1'b1);
    @(posedge clk); #1;
    enable = 1'b0;
    wait_done(tag, lat, exp);
  endtask

  initial begin
    int dcnt, pcnt;
    logic [2:0]  op;
    logic [31:0] a, b;
    rst = 1'b1; enable = 1'b1; stall_in = 1'b0; flush = 1'b0;
    mulop = 3'd0; rs1 = 32'd3; rs2 = 32'd5;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chkb("reset pause", pause, 1'b0);
    chkb("reset done", done, 1'b0);
    chk32("reset out", out, 32'h0);
    @(posedge clk); #1;
    enable = 1'b0; rst = 1'b0;

    // Multiply and divide examples.
    run_op("mul", 3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 33);
    run_op("mulh", 3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 33);
    run_op("mulhu", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
    run_op("mulhsu", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33);
    run_op("div", 3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33);
    run_op("rem", 3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33);
    run_op("divu", 3'd5, 32'd100, 32'd7, 32'd14, 33);
    run_op("remu", 3'd7, 32'd100, 32'd7, 32'd2, 33);

    // Single-cycle special cases.
    run_op("div0", 3'd4, 32'd5, 32'd0, 32'hFFFFFFFF, 1);
    run_op("rem0", 3'd6, 32'd5, 32'd0, 32'd5, 1);
    run_op("divovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run_op("removf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1);

    // Flush in IDLE suppresses acceptance.
    @(posedge clk); #1;
    enable = 1'b1; flush = 1'b1; mulop = 3'd5; rs1 = 32'd9; rs2 = 32'd2;
    @(negedge clk);
    chkb("idle_flush pause", pause, 1'b0);
    @(posedge clk); #1;
    enable = 1'b0; flush = 1'b0;
    dcnt = 0; pcnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (done) dcnt++;
      if (pause) pcnt++;
    end
    chk32("idle_flush done_seen", 32'(dcnt), 32'd0);
    chk32("idle_flush pause_seen", 32'(pcnt), 32'd0);

    // Flush at cycle 10 of a DIV.
    @(posedge clk); #1;
    enable = 1'b1; mulop = 3'd4; rs1 = 32'd100; rs2 = 32'd7;
    @(negedge clk);
    chkb("flush accept_pause", pause, 1'b1);
    @(posedge clk); #1;
    enable = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    chkb("flush cycle10 pause", pause, 1'b1);
    chkb("flush cycle10 done", done, 1'b0);
    @(posedge clk); #1;
    flush = 1'b0;
    dcnt = 0; pcnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dcnt++;
      if (pause) pcnt++;
    end
    chk32("flush done_seen", 32'(dcnt), 32'd0);
    chk32("flush pause_seen", 32'(pcnt), 32'd0);
    chk32("flush out_kept", out, last_out);

    // Reset at cycle 5 of a DIV.
    @(posedge clk); #1;
    enable = 1'b1; mulop = 3'd4; rs1 = 32'd100; rs2 = 32'd7;
    @(posedge clk); #1;
    enable = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chkb("rst cycle5 pause", pause, 1'b0);
    chkb("rst cycle5 done", done, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    dcnt = 0; pcnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dcnt++;
      if (pause) pcnt++;
    end
    chk32("rst done_seen", 32'(dcnt), 32'd0);
    chk32("rst pause_seen", 32'(pcnt), 32'd0);
    chk32("rst out", out, 32'h0);
    last_out = 32'h0;

    // stall_in held for 3 cycles in DONE with enable asserted.
    run_op("stall", 3'd5, 32'd1000, 32'd3, 32'd333, 33);
    stall_in = 1'b1; enable = 1'b1; mulop = 3'd0; rs1 = 32'd2; rs2 = 32'd2;
    for (int k = 0; k < 4; k++) begin
      chkb("stall done_held", done, 1'b1);
      chk32("stall out_held", out, 32'd333);
      chkb("stall pause_low", pause, 1'b0);
      if (k == 3) begin stall_in = 1'b0; enable = 1'b0; end
      @(negedge clk);
    end
    chkb("stall released done", done, 1'b0);
    chkb("stall released pause", pause, 1'b0);

    // Back-to-back: next op offered during DONE is accepted in the following IDLE cycle.
    run_op("b2b mul", 3'd0, 32'd3, 32'd4, 32'd12, 33);
    enable = 1'b1; mulop = 3'd5; rs1 = 32'd9; rs2 = 32'd2;
    chkb("b2b done_cycle pause", pause, 1'b0);
    @(negedge clk);
    chkb("b2b idle pause", pause, 1'b1);
    chkb("b2b idle done", done, 1'b0);
    @(posedge clk); #1;
    enable = 1'b0;
    wait_done("b2b divu", 33, 32'd4);

    // Randomized ops with corner-biased operands.
    for (int i = 0; i < 48; i++) begin
      op = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0: a = 32'h0;
        1: a = 32'h80000000;
        2: a = 32'hFFFFFFFF;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: b = 32'h0;
        1: b = 32'hFFFFFFFF;
        2: b = 32'($urandom_range(1, 9));
        default: b = $urandom;
      endcase
      run_op("rand", op, a, b, ref_res(op, a, b), ref_lat(op, a, b));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mext_seq.md
Name: mext_seq

Overview:
- Multi-cycle sequencer for the RV32M multiply/divide extension, instantiated in the EX stage beside the ALU and comparator.
- Inputs are the forwarded rs1/rs2 values, the M-op select and an enable from the control word.
- Runs an iterative shift-add multiplier or a restoring divider, and holds the pipeline with pause until the result is ready.
- Handles RISC-V divide-by-zero and signed-overflow cases in a single cycle.

Parameters:
- XLEN, 32, operand/result width.
- MUL_BITS_PER_CYCLE, 1, multiplier bits retired per BUSY cycle. Legal values: 1, 2, 4. Divide always retires 1 bit per cycle.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- enable  input  1  the EX instruction is an M-op.
- mulop  input  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- rs1  input  XLEN  forwarded operand 1.
- rs2  input  XLEN  forwarded operand 2.
- stall_in  input  1  pipeline held by another source (e.g. cache miss).
- flush  input  1  the EX instruction is killed (e.g. branch mispredict).
- out  output  XLEN  result. Valid when done=1.
- done  output  1  result valid this cycle.
- pause  output  1  stall IF/ID/EX and bubble MEM.

Behaviour:
- Clock is clk; reset is rst, synchronous and active-high. On rst: state=IDLE, out=0, done=0, counters and accumulators cleared. pause=0 while rst=1.
- State machine states: IDLE, BUSY, DONE.
- pause = (IDLE & enable & ~flush) | BUSY. This is combinational, so the pipeline stalls in the same cycle the op arrives.
- IDLE:
  - If enable & ~flush: latch mulop, latch operand magnitudes, latch the result-sign flags.
    - Signedness: rs1 signed for MUL/MULH/MULHSU/DIV/REM; rs2 signed for MUL/MULH/DIV/REM.
  - If the op is a divide/remainder with rs2==0 or signed overflow: go to DONE directly.
  - Otherwise go to BUSY with count=0.
- BUSY:
  - MUL*: 2*XLEN-bit accumulator, XLEN/MUL_BITS_PER_CYCLE cycles.
  - DIV*/REM*: restoring divider, XLEN cycles.
  - On the last cycle: apply sign correction (two's-complement negate), select the output, go to DONE.
- DONE:
  - done=1, pause=0, out held.
  - If stall_in=1: stay in DONE. out stays stable and the op is not restarted, even though enable is still high.
  - Else go to IDLE. A new enable is accepted on the following IDLE cycle.
- flush in BUSY or DONE: go to IDLE next cycle; done=0; out unchanged; no result is produced. flush in IDLE suppresses acceptance.
- rst mid-operation: IDLE next cycle, all state cleared, no residual done.
- Result selection:
  - MUL: product[XLEN-1:0].
  - MULH/MULHSU/MULHU: product[2XLEN-1:XLEN].
  - DIV/DIVU: quotient.
  - REM/REMU: remainder. Remainder sign follows the dividend; quotient is negative iff operand signs differ and the divisor is non-zero.
- Special cases, 1 pause cycle:
  - Divide by zero: DIV/DIVU give all-ones; REM/REMU give rs1.
  - Signed overflow (rs1=0x80000000, rs2=0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
- Latency with XLEN=32 and MUL_BITS_PER_CYCLE=1, accept cycle = 0:
  - pause high in cycles 0..32.
  - done high in cycle 33.
  - Special cases: pause in cycle 0 only; done in cycle 1.

Optional Feature:
- Macro: MEXT_FAST_ZERO_EN.
- When defined:
  - Any MUL* with rs1==0 or rs2==0 goes IDLE to DONE with out=0.
  - DIV/DIVU/REM/REMU with rs1==0 goes IDLE to DONE with out=0, unless rs2==0, in which case the divide-by-zero rules apply.
  - pause is high for 1 cycle in both cases.
- When undefined: these ops take the full BUSY latency. Results are identical either way.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD → pause high cycles 0–32, done cycle 33, out=0xFFFFFFEB.
- MULH 0x80000000*0x80000000 → 0x40000000. MULHU 0xFFFFFFFF*0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF*0xFFFFFFFF → 0xFFFFFFFF.
- Divide, each done at cycle 33:
  - DIV 0xFFFFFFF9/2 → 0xFFFFFFFD.
  - REM same operands → 0xFFFFFFFF.
  - DIVU 100/7 → 14.
  - REMU 100/7 → 2.
- Special cases, each done at cycle 1 with pause high 1 cycle:
  - DIV 5/0 → 0xFFFFFFFF.
  - REM 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM same operands → 0.
- Control:
  - flush asserted at cycle 10 of a DIV → pause=0 from cycle 11, state IDLE, done never asserts.
  - rst at cycle 5 behaves the same, with out=0.
  - stall_in high for 3 cycles in DONE → done and out held 4 cycles, no restart.
- Back-to-back: MUL 3*4, then enable stays high with DIVU 9/2 the cycle after DONE → out=12, then the second op is accepted in the next IDLE cycle with out=4.
